bloom_filter_array: RTL and testbench

- Bloom-filter membership stage that sits directly downstream of the FNV-1a hash block and consumes its HASH_SIZE-bit digest.
- Derives NUM_PROBES bit indices from each digest by double hashing.
- Insert: sets those bits in a BL_SIZE-bit array. Query: tests them.
- One probe (read-modify-write of one array word) per cycle, a single-cycle response pulse, a sweeping clear, and a saturating element counter.

---
 rtl/bloom_filter_array.sv | 113 +++++++++++
 tb/tb_bloom_filter_array.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bloom_filter_array.sv
// Bloom-filter membership stage: double-hashed probe indices from an FNV-1a digest,
// one read-modify-write probe per cycle, a word-sweeping clear and a saturating element counter.
module bloom_filter_array #(
  parameter int HASH_SIZE  = 32,
  parameter int BL_SIZE    = 1024,
  parameter int WORD_W     = 32,
  parameter int NUM_PROBES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [HASH_SIZE-1:0] req_hash,
  input  logic                 clear_req,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic                 resp_op,
  output logic                 busy,
  output logic [CNT_W-1:0]     elem_count,
  output logic                 sat
);

  localparam int IDX_W  = $clog2(BL_SIZE);
  localparam int NWORDS = BL_SIZE / WORD_W;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int WPTR_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PCNT_W = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;

  typedef enum logic [1:0] {IDLE, PROBE, RESP, CLEAR} state_t;

  state_t              state, state_nx;
  logic [WORD_W-1:0]   mem [NWORDS];
  logic                op_r;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    h2;
  logic [PCNT_W-1:0]   pcnt;
  logic                hit_acc;
  logic [WPTR_W-1:0]   wptr;
  logic [WPTR_W-1:0]   word_sel;
  logic [BIT_W-1:0]    bit_sel;
  logic                cur_bit;
  logic                last_probe;
  logic                last_word;

  assign word_sel   = idx[IDX_W-1:BIT_W];
  assign bit_sel    = idx[BIT_W-1:0];
  assign cur_bit    = mem[word_sel][bit_sel];
  assign last_probe = (pcnt == PCNT_W'(NUM_PROBES - 1));
  assign last_word  = (wptr == WPTR_W'(NWORDS - 1));

  assign req_ready  = (state == IDLE) && !clear_req;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign resp_hit   = (state == RESP) && hit_acc;
  assign resp_op    = (state == RESP) && op_r;
  assign sat        = &elem_count;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clear_req)      state_nx = CLEAR;
        else if (req_valid) state_nx = PROBE;
      end
      PROBE:   if (last_probe) state_nx = RESP;
      RESP:    state_nx = IDLE;
      CLEAR:   if (last_word) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // idx walks h1, h1+h2, h1+2*h2, ... so no multiplier is needed; IDX_W wrap gives the mod.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      elem_count <= '0;
      for (int w = 0; w < NWORDS; w++) mem[w] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (clear_req) begin
            wptr <= '0;
          end else if (req_valid) begin
            op_r    <= req_op;
            idx     <= req_hash[IDX_W-1:0];
            h2      <= req_hash[HASH_SIZE-1 -: IDX_W] | IDX_W'(1);
            pcnt    <= '0;
            hit_acc <= 1'b1;
          end
        end
        PROBE: begin
          hit_acc <= hit_acc & cur_bit;
          if (op_r) mem[word_sel][bit_sel] <= 1'b1;
          idx  <= idx + h2;
          pcnt <= pcnt + PCNT_W'(1);
        end
        RESP: begin
          if (op_r && !hit_acc && !sat) elem_count <= elem_count + CNT_W'(1);
        end
        CLEAR: begin
          mem[wptr] <= '0;
          wptr      <= wptr + WPTR_W'(1);
          if (last_word) elem_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_filter_array.sv
// Directed plus randomized bench for bloom_filter_array against a bit-array reference model;
// a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_bloom_filter_array;

  localparam int NP     = 4;
  localparam int BL     = 1024;
  localparam int NWORDS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_hash;
  logic        clear_req;
  logic        req_ready, resp_valid, resp_hit, resp_op, busy, sat;
  logic [15:0] elem_count;
  logic        req_ready2, resp_valid2, resp_hit2, resp_op2, busy2, sat2;
  logic [1:0]  elem_count2;

  int tests = 0;
  int fails = 0;
  bit mb [BL];
  int cnt;
  logic [31:0] pool [8];

  always #5 clk = ~clk;

  bloom_filter_array dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_hash(req_hash), .clear_req(clear_req), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_op(resp_op), .busy(busy), .elem_count(elem_count), .sat(sat)
  );

  bloom_filter_array #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2), .req_op(req_op),
    .req_hash(req_hash), .clear_req(clear_req), .resp_valid(resp_valid2), .resp_hit(resp_hit2),
    .resp_op(resp_op2), .busy(busy2), .elem_count(elem_count2), .sat(sat2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    logic [BL-1:0] o, e;
    int diff;
    diff = 0;
    for (int w = 0; w < NWORDS; w++)
      for (int b = 0; b < 32; b++) begin
        o[w*32+b] = dut.mem[w][b];
        e[w*32+b] = mb[w*32+b];
        if (o[w*32+b] !== e[w*32+b]) diff++;
      end
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d differing bits expected=0", tag, diff);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < BL; k++) mb[k] = 1'b0;
    cnt = 0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt"},  elem_count, cnt);
    chk({tag, "_sat"},  sat, (cnt == 65535));
    chk({tag, "_cnt2"}, elem_count2, (cnt > 3) ? 3 : cnt);
    chk({tag, "_sat2"}, sat2, (cnt >= 3));
  endtask

  task automatic run_req(input bit op, input logic [31:0] hash, input string tag);
    int h1, h2, ix;
    bit exp_hit;
    logic early;
    h1 = hash % BL;
    h2 = ((hash >> 22) | 1) % BL;
    exp_hit = 1'b1;
    for (int i = 0; i < NP; i++) begin
      ix = (h1 + i * h2) % BL;
      if (!mb[ix]) exp_hit = 1'b0;
    end
    if (op) begin
      for (int i = 0; i < NP; i++) mb[(h1 + i * h2) % BL] = 1'b1;
      if (!exp_hit && cnt < 65535) cnt++;
    end
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = op;
    req_hash  = hash;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_hash  = $urandom;
    early = 1'b0;
    for (int k = 1; k <= NP; k++) begin
      @(negedge clk);
      early = early | resp_valid;
    end
    chk({tag, "_early"}, early, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_hit"}, resp_hit, exp_hit);
    chk({tag, "_op"}, resp_op, op);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {resp_valid, busy, req_ready}, 3'b001);
    chk_counts(tag);
    chk_mem({tag, "_mem"});
  endtask

  task automatic do_clear(input string tag);
    logic bad;
    @(negedge clk);
    clear_req = 1'b1;
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_hash  = 32'h0040_0005;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    req_valid = 1'b0;
    bad = 1'b0;
    for (int k = 1; k <= NWORDS; k++) begin
      @(negedge clk);
      if (!busy || req_ready || resp_valid) bad = 1'b1;
    end
    chk({tag, "_busy_span"}, bad, 1'b0);
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, req_ready}, 2'b01);
    model_clear();
    chk_counts(tag);
    chk_mem({tag, "_mem"});
  endtask

  task automatic do_reset_mid(input string tag);
    logic seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_hash  = 32'h0100_0123;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk({tag, "_idle"}, {busy, req_ready}, 2'b01);
    seen = resp_valid;
    for (int k = 0; k < NP + 2; k++) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    chk({tag, "_no_resp"}, seen, 1'b0);
    chk_counts(tag);
    chk_mem({tag, "_mem"});
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 1'b0;
    req_hash = '0;
    clear_req = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {resp_valid, resp_hit, resp_op, busy, req_ready}, 5'b00001);
    chk_counts("reset");
    chk_mem("reset_mem");

    run_req(1'b0, 32'h0040_0005, "empty_query");
    run_req(1'b1, 32'h0040_0005, "insert_first");
    run_req(1'b0, 32'h0040_0005, "query_present");
    run_req(1'b1, 32'h0040_0005, "reinsert");
    run_req(1'b0, 32'h0080_0005, "partial_overlap");
    run_req(1'b1, 32'h00C0_03FF, "wrap_insert");
    run_req(1'b0, 32'h00C0_03FF, "wrap_query");

    do_clear("clear_prio");
    run_req(1'b0, 32'h0040_0005, "query_after_clear");

    run_req(1'b1, 32'h0040_0005, "sat_ins1");
    run_req(1'b1, 32'h0080_0105, "sat_ins2");
    run_req(1'b1, 32'h0100_0200, "sat_ins3");
    run_req(1'b1, 32'h0200_0300, "sat_ins4");
    run_req(1'b1, 32'h0400_0010, "sat_ins5");

    do_reset_mid("reset_mid");

    for (int p = 0; p < 8; p++) pool[p] = $urandom;
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0)      do_clear("rnd_clear");
      else if (r < 5)  run_req(1'($urandom), $urandom, "rnd_fresh");
      else             run_req(1'($urandom), pool[$urandom_range(0, 7)], "rnd_pool");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
